proj_kmer_hash_pipe: RTL and testbench
======================================

# proj_kmer_hash_pipe

Streaming k-mer extractor and multi-seed hasher for the MinHash datapath. It accepts one nucleotide per handshake and keeps a sliding window of the last KMER_LEN bases. For every complete k-mer it emits NUM_SEEDS MurmurHash3-style signatures in parallel through a 2-stage, backpressure-aware pipeline. It sits between the base decoder and the per-seed min-sorters, and carries sequence boundaries and k-mer position with each output.

## Interface
- DATA_BITS, 2: bits per base.
- KMER_LEN, 16: bases per k-mer, ≥2.
- HASHER_DATA_BITS, 32: hash word width W, ≥16.
- NUM_SEEDS, 4: parallel hash lanes, ≥1.
- POS_BITS, 16: width of the k-mer position counter.
- clk  in  1  clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  base available.
- in_ready  out  1  block can accept a base this cycle.
- in_data  in  DATA_BITS  nucleotide code.
- in_last  in  1  qualifies in_data as the final base of the sequence.
- start_over  in  1  synchronous window clear.
- seeds  in  NUM_SEEDS×W  per-lane seed; must be held stable while the pipeline is non-empty.
- full  out  1  window holds KMER_LEN bases.
- out_valid  out  1  signatures valid.
- out_ready  in  1  downstream accepts.
- out_signature  out  NUM_SEEDS×W  lane i hash.
- out_pos  out  POS_BITS  index of the k-mer's first base in its sequence, mod 2^POS_BITS.
- out_last  out  1  k-mer was formed by the in_last base.

## Operation
- Accept: acc = in_valid & in_ready.
- Window: on acc, shift left by DATA_BITS and insert in_data at the LSBs. The oldest base ends up in the MSBs.
- Base counter cnt: 0..KMER_LEN, saturating. full = (cnt == KMER_LEN).
- A k-mer completes on acc when the post-shift count equals KMER_LEN.
- Word: the window is zero-extended to W. If KMER_LEN·DATA_BITS > W, the window is XOR-folded in W-bit chunks from the LSB, with the top chunk zero-padded.
- Lane i hash, all arithmetic mod 2^W:
  - k = ROL15(word) · 0x1b873593
  - h = (ROL13(seeds[i]) ^ k) · 5 + 0xe6546b64
  - Constants are truncated or zero-extended to W.
- Position counter pc:
  - Reset and cleared at every sequence start.
  - Increments each time a k-mer is emitted into S1.
  - out_pos = pc value at emission. The first k-mer of a sequence has out_pos = 0. pc wraps silently.
- in_last on acc:
  - If a k-mer completes, it carries last = 1.
  - After that edge, the window, cnt and pc clear to 0.
  - A sequence shorter than KMER_LEN emits nothing.
- start_over clears the window, cnt and pc.
  - If acc happens in the same cycle, the clear applies first and the accepted base becomes the first base of the new sequence (cnt = 1).
  - In-flight S1/S2 entries are not flushed.
- start_over together with an in_last base: the base is loaded, then cleared by in_last. The result is cnt = 0.

## Timing
- Pipeline:
  - S1 registers {word, pos, last, valid}.
  - S2 is the output register {signatures, pos, last}, driven from S1 through the hash logic.
- s2_adv = ~out_valid | out_ready.
- s1_adv = ~s1_valid | s2_adv.
- in_ready = s1_adv (combinational). Non-completing bases are also blocked while stalled.
- Latency: a k-mer completed by acc at edge N appears on out_valid after edge N+1 if out_ready stays high.
- Throughput: one k-mer per cycle when out_ready is held high.
- Outputs stay stable while out_valid & ~out_ready.
- Reset values:
  - out_valid = 0, out_signature = 0, out_pos = 0, out_last = 0, full = 0.
  - S1 invalid, window = 0, cnt = 0, pc = 0.
  - in_ready = 1 from the first cycle after reset release.
- Reset asserted mid-stream discards all state immediately (asynchronous).

## Test plan
- Reset, then seeds all 0: 16 bases of 2'b00 back-to-back with out_ready = 1 → no out_valid for bases 1–15. On the 16th base, all lanes = 0xe6546b64 with out_pos = 0, visible after edge N+1.
- seeds[1] = 1, other seeds 0, zero k-mer → lane 1 = 0xe6550b64, other lanes = 0xe6546b64. Then send 4 more bases → 4 outputs on consecutive cycles with out_pos = 1, 2, 3, 4.
- Hold out_ready = 0 with a continuous input stream → in_ready drops after S1 and S2 fill, and outputs stay constant. Release → no k-mer lost or duplicated, and out_pos is contiguous.
- Send 17 bases with in_last on the 17th → exactly 2 outputs, the second with out_last = 1. The next base yields full = 0 and cnt = 1.
- Send 10 bases, then start_over together with a base → full stays 0 until 15 more bases arrive. Next out_pos = 0.
- Set KMER_LEN = 20 (40-bit window, W = 32): compare the XOR-fold against a reference model across 1000 random bases, including assertion of rst_n mid-stream.

Source files
------------

// File: rtl/proj_kmer_hash_pipe_if.sv
// Stream bundle for proj_kmer_hash_pipe.
//   Input side : in_valid/in_ready/in_data/in_last, one nucleotide per transfer.
//   Output side: out_valid/out_ready/out_signature/out_pos/out_last, one k-mer per transfer.
// Handshake: a transfer happens on a rising clk edge where valid & ready are both
// high. Once valid is raised, the source holds valid and its payload stable
// until that transfer. ready may depend combinationally on the sink's state,
// but never on valid.
// modport slave is the hasher side; modport master is the side that feeds
// bases and consumes signatures.
interface proj_kmer_hash_pipe_if #(
  parameter int DATA_BITS        = 2,
  parameter int HASHER_DATA_BITS = 32,
  parameter int NUM_SEEDS        = 4,
  parameter int POS_BITS         = 16
);
  logic                                  in_valid;
  logic                                  in_ready;
  logic [DATA_BITS-1:0]                  in_data;
  logic                                  in_last;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [NUM_SEEDS*HASHER_DATA_BITS-1:0] out_signature;
  logic [POS_BITS-1:0]                   out_pos;
  logic                                  out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_signature, out_pos, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_signature, out_pos, out_last
  );
endinterface

// File: rtl/proj_kmer_hash_pipe.sv
// Streaming k-mer extractor and multi-seed hasher.
// Keeps a sliding window of the last KMER_LEN bases. Each complete k-mer is
// folded to a W-bit word in stage S1. Stage S2 then registers NUM_SEEDS
// MurmurHash3-style lane hashes of that word.
// Ports:
//   clk, rst_n  : clock and asynchronous active-low reset
//   start_over  : synchronous clear of window, base count and position counter
//   seeds       : per-lane seeds, lane i at [i*W +: W]; held stable while busy
//   full        : window holds KMER_LEN bases
//   bus         : input base stream and output signature stream (slave side)
module proj_kmer_hash_pipe #(
  parameter int DATA_BITS        = 2,
  parameter int KMER_LEN         = 16,
  parameter int HASHER_DATA_BITS = 32,
  parameter int NUM_SEEDS        = 4,
  parameter int POS_BITS         = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start_over,
  input  logic [NUM_SEEDS*HASHER_DATA_BITS-1:0] seeds,
  output logic                                  full,
  proj_kmer_hash_pipe_if.slave                  bus
);
  localparam int W        = HASHER_DATA_BITS;
  localparam int WIN_BITS = KMER_LEN * DATA_BITS;
  localparam int NCHUNK   = (WIN_BITS + W - 1) / W;
  localparam int PAD_BITS = NCHUNK * W;
  localparam int CNT_W    = $clog2(KMER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(KMER_LEN);
  localparam logic [W-1:0] C1 = W'(32'h1b873593);
  localparam logic [W-1:0] C2 = W'(32'he6546b64);

  function automatic logic [W-1:0] rol(input logic [W-1:0] x, input int r);
    return (x << r) | (x >> (W - r));
  endfunction

  function automatic logic [W-1:0] lane_hash(input logic [W-1:0] word,
                                             input logic [W-1:0] seed);
    logic [W-1:0] k;
    logic [W-1:0] m;
    k = rol(word, 15) * C1;
    m = rol(seed, 13) ^ k;
    return (m << 2) + m + C2;
  endfunction

  // window / counters
  logic [WIN_BITS-1:0] win;
  logic [CNT_W-1:0]    cnt;
  logic [POS_BITS-1:0] pc;

  // S1
  logic                s1_valid;
  logic [W-1:0]        s1_word;
  logic [POS_BITS-1:0] s1_pos;
  logic                s1_last;

  // S2 (output register)
  logic                          s2_valid;
  logic [NUM_SEEDS*W-1:0]        s2_sig;
  logic [POS_BITS-1:0]           s2_pos;
  logic                          s2_last;

  logic s1_adv, s2_adv, acc, complete, emit;
  logic [WIN_BITS-1:0] base_win, sh_win, nxt_win;
  logic [CNT_W-1:0]    base_cnt, sh_cnt, nxt_cnt;
  logic [POS_BITS-1:0] base_pc, nxt_pc;
  logic [PAD_BITS-1:0] win_pad;
  logic [W-1:0]        fold_word;
  logic [NUM_SEEDS*W-1:0] sig_comb;

  assign s2_adv = ~s2_valid | bus.out_ready;
  assign s1_adv = ~s1_valid | s2_adv;
  assign acc    = bus.in_valid & s1_adv;

  always_comb begin
    // start_over clears first, so a base accepted in the same cycle starts
    // the new sequence.
    base_win = start_over ? '0 : win;
    base_cnt = start_over ? '0 : cnt;
    base_pc  = start_over ? '0 : pc;
    sh_win   = {base_win[WIN_BITS-DATA_BITS-1:0], bus.in_data};
    sh_cnt   = (base_cnt == CNT_FULL) ? base_cnt : base_cnt + CNT_W'(1);
    complete = (sh_cnt == CNT_FULL);
    emit     = acc & complete;
    nxt_win  = base_win;
    nxt_cnt  = base_cnt;
    nxt_pc   = base_pc;
    if (acc) begin
      if (bus.in_last) begin
        nxt_win = '0;
        nxt_cnt = '0;
        nxt_pc  = '0;
      end else begin
        nxt_win = sh_win;
        nxt_cnt = sh_cnt;
        nxt_pc  = emit ? base_pc + POS_BITS'(1) : base_pc;
      end
    end
  end

  // XOR-fold the post-shift window into W bits; the top chunk is zero-padded.
  always_comb begin
    win_pad = '0;
    win_pad[WIN_BITS-1:0] = sh_win;
    fold_word = '0;
    for (int c = 0; c < NCHUNK; c++) fold_word = fold_word ^ win_pad[c*W +: W];
  end

  always_comb begin
    sig_comb = '0;
    for (int i = 0; i < NUM_SEEDS; i++)
      sig_comb[i*W +: W] = lane_hash(s1_word, seeds[i*W +: W]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win      <= '0;
      cnt      <= '0;
      pc       <= '0;
      s1_valid <= 1'b0;
      s1_word  <= '0;
      s1_pos   <= '0;
      s1_last  <= 1'b0;
      s2_valid <= 1'b0;
      s2_sig   <= '0;
      s2_pos   <= '0;
      s2_last  <= 1'b0;
    end else begin
      win <= nxt_win;
      cnt <= nxt_cnt;
      pc  <= nxt_pc;
      if (s1_adv) begin
        s1_valid <= emit;
        if (emit) begin
          s1_word <= fold_word;
          s1_pos  <= base_pc;
          s1_last <= bus.in_last;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_sig  <= sig_comb;
          s2_pos  <= s1_pos;
          s2_last <= s1_last;
        end
      end
    end
  end

  assign full              = (cnt == CNT_FULL);
  assign bus.in_ready      = s1_adv;
  assign bus.out_valid     = s2_valid;
  assign bus.out_signature = s2_sig;
  assign bus.out_pos       = s2_pos;
  assign bus.out_last      = s2_last;
endmodule

// File: tb/tb_proj_kmer_hash_pipe.sv
module tb_proj_kmer_hash_pipe;
  localparam int W  = 32;
  localparam int NS = 4;
  localparam int PB = 16;
  localparam int EW = 1 + PB + NS*W;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // shared stimulus
  logic          in_valid, in_last, start_over;
  logic [1:0]    in_data;
  logic [NS*W-1:0] seeds;
  logic          rdy_fixed, rand_rdy, rnd_bit;
  logic          full_a, full_b;

  proj_kmer_hash_pipe_if #(.DATA_BITS(2), .HASHER_DATA_BITS(W), .NUM_SEEDS(NS), .POS_BITS(PB)) ifa ();
  proj_kmer_hash_pipe_if #(.DATA_BITS(2), .HASHER_DATA_BITS(W), .NUM_SEEDS(NS), .POS_BITS(PB)) ifb ();

  assign ifa.in_valid  = in_valid;
  assign ifa.in_data   = in_data;
  assign ifa.in_last   = in_last;
  assign ifa.out_ready = rand_rdy ? rnd_bit : rdy_fixed;
  assign ifb.in_valid  = in_valid;
  assign ifb.in_data   = in_data;
  assign ifb.in_last   = in_last;
  assign ifb.out_ready = rand_rdy ? rnd_bit : rdy_fixed;

  proj_kmer_hash_pipe #(.DATA_BITS(2), .KMER_LEN(16), .HASHER_DATA_BITS(W), .NUM_SEEDS(NS), .POS_BITS(PB))
    dut_a (.clk(clk), .rst_n(rst_n), .start_over(start_over), .seeds(seeds), .full(full_a), .bus(ifa));
  proj_kmer_hash_pipe #(.DATA_BITS(2), .KMER_LEN(20), .HASHER_DATA_BITS(W), .NUM_SEEDS(NS), .POS_BITS(PB))
    dut_b (.clk(clk), .rst_n(rst_n), .start_over(start_over), .seeds(seeds), .full(full_b), .bus(ifb));

  initial begin
    rnd_bit = 1'b1;
    forever begin
      @(posedge clk); #1;
      rnd_bit = ($urandom_range(0, 3) != 0);
    end
  end

  // scoreboard
  int n_checks = 0;
  int n_errs   = 0;
  logic [EW-1:0] exp_q_a[$];
  logic [EW-1:0] exp_q_b[$];
  int            log_cyc[$];
  logic [PB-1:0] log_pos[$];
  logic          log_last[$];
  logic [NS*W-1:0] log_sig[$];
  int last_acc_cyc = 0;

  task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // reference model
  logic [63:0] m_win[2];
  int          m_cnt[2];
  logic [PB-1:0] m_pc[2];

  function automatic logic [31:0] m_fold(input logic [63:0] win, input int nb);
    logic [31:0] f;
    f = '0;
    for (int b = 0; b < nb; b++) f[b % 32] = f[b % 32] ^ win[b];
    return f;
  endfunction

  function automatic logic [31:0] m_rol(input logic [31:0] x, input int r);
    return (x << r) | (x >> (32 - r));
  endfunction

  function automatic logic [31:0] m_hash(input logic [31:0] word, input logic [31:0] seed);
    logic [31:0] k;
    k = m_rol(word, 15) * 32'h1b873593;
    return (m_rol(seed, 13) ^ k) * 32'd5 + 32'he6546b64;
  endfunction

  task automatic model_step(input int d, input bit acc, input logic [1:0] data,
                            input bit last, input bit so);
    int k;
    logic [NS*W-1:0] sig;
    k = (d == 0) ? 16 : 20;
    if (so) begin
      m_win[d] = '0; m_cnt[d] = 0; m_pc[d] = '0;
    end
    if (acc) begin
      m_win[d] = ((m_win[d] << 2) | 64'(data)) & ((64'd1 << (2*k)) - 64'd1);
      if (m_cnt[d] < k) m_cnt[d]++;
      if (m_cnt[d] == k) begin
        for (int i = 0; i < NS; i++)
          sig[i*W +: W] = m_hash(m_fold(m_win[d], 2*k), seeds[i*W +: W]);
        if (d == 0) exp_q_a.push_back({last, m_pc[d], sig});
        else        exp_q_b.push_back({last, m_pc[d], sig});
        m_pc[d] = m_pc[d] + 1'b1;
      end
      if (last) begin
        m_win[d] = '0; m_cnt[d] = 0; m_pc[d] = '0;
      end
    end
  endtask

  // output monitors: the head of the queue must be on the bus while valid
  always @(negedge clk) begin
    if (rst_n && ifa.out_valid) begin
      if (exp_q_a.size() == 0) check("a_unexpected_out", EW'(ifa.out_valid), '0);
      else begin
        check("a_out", {ifa.out_last, ifa.out_pos, ifa.out_signature}, exp_q_a[0]);
        if (ifa.out_ready) begin
          void'(exp_q_a.pop_front());
          log_cyc.push_back(cyc);
          log_pos.push_back(ifa.out_pos);
          log_last.push_back(ifa.out_last);
          log_sig.push_back(ifa.out_signature);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ifb.out_valid) begin
      if (exp_q_b.size() == 0) check("b_unexpected_out", EW'(ifb.out_valid), '0);
      else begin
        check("b_out", {ifb.out_last, ifb.out_pos, ifb.out_signature}, exp_q_b[0]);
        if (ifb.out_ready) void'(exp_q_b.pop_front());
      end
    end
  end

  // driver tasks (entered and left at posedge + 1)
  task automatic drive_cycle(input logic [1:0] d, input bit l, input bit so,
                             input bit v, output bit acc_a);
    bit acc_b;
    in_valid = v; in_data = d; in_last = l; start_over = so;
    @(negedge clk);
    check("a_full", EW'(full_a), EW'(m_cnt[0] == 16));
    check("b_full", EW'(full_b), EW'(m_cnt[1] == 20));
    acc_a = v & ifa.in_ready;
    acc_b = v & ifb.in_ready;
    if (acc_a) last_acc_cyc = cyc;
    model_step(0, acc_a, d, l, so);
    model_step(1, acc_b, d, l, so);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; start_over = 1'b0;
  endtask

  task automatic send_base(input logic [1:0] d, input bit l, input bit so);
    bit a;
    int tries;
    tries = 0;
    do begin
      drive_cycle(d, l, so, 1'b1, a);
      tries++;
    end while (!a && tries < 200);
    if (!a) check("accept_timeout", EW'(a), EW'(1));
  endtask

  task automatic idle(input int n);
    bit a;
    repeat (n) drive_cycle(2'b00, 1'b0, 1'b0, 1'b0, a);
  endtask

  task automatic clear_logs();
    log_cyc.delete(); log_pos.delete(); log_last.delete(); log_sig.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_last = 1'b0; start_over = 1'b0; in_data = '0;
    #1;
    check("rst_a_valid", EW'(ifa.out_valid), '0);
    check("rst_a_sig",   EW'(ifa.out_signature), '0);
    check("rst_a_pos",   EW'(ifa.out_pos), '0);
    check("rst_a_last",  EW'(ifa.out_last), '0);
    check("rst_a_full",  EW'(full_a), '0);
    check("rst_b_valid", EW'(ifb.out_valid), '0);
    check("rst_b_full",  EW'(full_b), '0);
    for (int d = 0; d < 2; d++) begin
      m_win[d] = '0; m_cnt[d] = 0; m_pc[d] = '0;
    end
    exp_q_a.delete(); exp_q_b.delete(); clear_logs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_a_in_ready", EW'(ifa.in_ready), EW'(1));
    check("rst_b_in_ready", EW'(ifb.in_ready), EW'(1));
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc;
    bit a;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; start_over = 1'b0; in_data = '0;
    rdy_fixed = 1'b1; rand_rdy = 1'b0; seeds = '0;
    @(posedge clk); #1;
    do_reset();

    // zero k-mer, zero seeds: single output two edges after the 16th base
    for (int i = 0; i < 16; i++) send_base(2'b00, 1'b0, 1'b0);
    idle(3);
    check("t1_count", EW'(log_pos.size()), EW'(1));
    if (log_pos.size() >= 1) begin
      check("t1_latency", EW'(log_cyc[0]), EW'(last_acc_cyc + 2));
      check("t1_sig", EW'(log_sig[0]), EW'({4{32'he6546b64}}));
      check("t1_pos", EW'(log_pos[0]), '0);
    end

    // seed 1 on lane 1, then 4 more bases on consecutive cycles
    rst_n = 1'b0;
    seeds = {32'h0, 32'h0, 32'h1, 32'h0};
    do_reset();
    for (int i = 0; i < 20; i++) send_base(2'b00, 1'b0, 1'b0);
    idle(3);
    check("t2_count", EW'(log_pos.size()), EW'(5));
    if (log_pos.size() == 5) begin
      check("t2_sig", EW'(log_sig[0]),
            EW'({32'he6546b64, 32'he6546b64, 32'he6550b64, 32'he6546b64}));
      for (int i = 1; i < 5; i++) begin
        check("t2_pos", EW'(log_pos[i]), EW'(i));
        check("t2_consecutive", EW'(log_cyc[i]), EW'(log_cyc[0] + i));
      end
    end

    // backpressure: continuous input with downstream stalled
    clear_logs();
    rdy_fixed = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 12; i++) begin
      drive_cycle(2'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b1, a);
      if (a) n_acc++;
    end
    in_valid = 1'b1;
    @(negedge clk);
    check("t3_in_ready_low", EW'(ifa.in_ready), '0);
    check("t3_out_valid", EW'(ifa.out_valid), EW'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    rdy_fixed = 1'b1;
    idle(5);
    check("t3_count", EW'(log_pos.size()), EW'(n_acc));
    check("t3_drained", EW'(exp_q_a.size()), '0);

    // 17 bases with in_last on the 17th
    do_reset();
    for (int i = 0; i < 17; i++) send_base(2'($urandom_range(0, 3)), i == 16, 1'b0);
    idle(3);
    check("t4_count", EW'(log_pos.size()), EW'(2));
    if (log_pos.size() == 2) begin
      check("t4_last0", EW'(log_last[0]), '0);
      check("t4_last1", EW'(log_last[1]), EW'(1));
      check("t4_pos1",  EW'(log_pos[1]), EW'(1));
    end
    send_base(2'b01, 1'b0, 1'b0);
    @(negedge clk);
    check("t4_full_after", EW'(full_a), '0);
    @(posedge clk); #1;

    // start_over together with a base
    do_reset();
    for (int i = 0; i < 10; i++) send_base(2'($urandom_range(0, 3)), 1'b0, 1'b0);
    send_base(2'b10, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) send_base(2'($urandom_range(0, 3)), 1'b0, 1'b0);
    @(negedge clk);
    check("t5_not_full", EW'(full_a), '0);
    @(posedge clk); #1;
    send_base(2'b11, 1'b0, 1'b0);
    @(negedge clk);
    check("t5_full", EW'(full_a), EW'(1));
    @(posedge clk); #1;
    idle(3);
    check("t5_count", EW'(log_pos.size()), EW'(1));
    if (log_pos.size() == 1) check("t5_pos", EW'(log_pos[0]), '0);

    // random stream with random backpressure and a mid-stream reset
    rst_n = 1'b0;
    for (int i = 0; i < NS; i++) seeds[i*W +: W] = $urandom();
    do_reset();
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (i == 500) do_reset();
      send_base(2'($urandom_range(0, 3)), $urandom_range(0, 63) == 0,
                $urandom_range(0, 63) == 0);
    end
    rand_rdy = 1'b0;
    idle(6);
    check("t6_drained_a", EW'(exp_q_a.size()), '0);
    check("t6_drained_b", EW'(exp_q_b.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
